// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two registered read ports,
// optional hardwired-zero register 0, optional write-to-read bypass, read-valid strobe.
module reg_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2,
  output logic                  VALID_R
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
  logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
  logic                  vld_q;
  logic                  wr_en;
  logic [DEPTH-1:0]      wr_dec_d;

  // Writes to register 0 are dropped when it is hardwired to zero.
  assign wr_en = WRITE && !((ZERO_REG != 0) && (ADDR_W == '0));

  always_comb begin
    wr_dec_d = '0;
    if (wr_en) wr_dec_d[ADDR_W] = 1'b1;
  end

  function automatic logic [DATA_WIDTH-1:0] rd_mux(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  wen,
    input logic [ADDR_WIDTH-1:0] waddr,
    input logic [DATA_WIDTH-1:0] wdata
  );
    if ((ZERO_REG != 0) && (addr == '0))
      return '0;
    else if ((BYPASS != 0) && wen && (waddr == addr))
      return wdata;
    else
      return stored;
  endfunction

  always_comb begin
    rd1_d = rd_mux(ADDR_R1, regs_q[ADDR_R1], wr_en, ADDR_W, DATA_W);
    rd2_d = rd_mux(ADDR_R2, regs_q[ADDR_R2], wr_en, ADDR_W, DATA_W);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      rd1_q <= '0;
      rd2_q <= '0;
      vld_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_dec_d[i]) regs_q[i] <= DATA_W;
      if (READ) begin
        rd1_q <= rd1_d;
        rd2_q <= rd2_d;
      end
      vld_q <= READ;
    end
  end

  assign DATA_R1 = rd1_q;
  assign DATA_R2 = rd2_q;
  assign VALID_R = vld_q;

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised register file built as the successor to the fixed 32x32 register and 5x32 decoder primitives. It generalises data width and depth and provides one write port and two registered read ports. It also adds write-to-read bypass, an optional hardwired-zero register 0, and a read-valid strobe. It sits between the control unit and the ALU in the CS147DV datapath and replaces hand-instantiated REG32 banks.

Parameters:
DATA_WIDTH, 32, bits per register and per data port.
ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH registers.
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary storage.
BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to the read output; 0 = the read returns the pre-write contents.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESET  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
READ  input  1  read strobe; samples both read addresses this edge.
WRITE  input  1  write strobe.
ADDR_R1  input  ADDR_WIDTH  read port 1 address.
ADDR_R2  input  ADDR_WIDTH  read port 2 address.
ADDR_W  input  ADDR_WIDTH  write address.
DATA_W  input  DATA_WIDTH  write data.
DATA_R1  output  DATA_WIDTH  registered read data, port 1.
DATA_R2  output  DATA_WIDTH  registered read data, port 2.
VALID_R  output  1  high for exactly the cycle after each edge that sampled READ=1.

Behaviour:
- Reset: RESET=1 at a rising edge clears every register to 0, and DATA_R1, DATA_R2 and VALID_R to 0.
  - RESET overrides READ and WRITE in the same cycle; no write commits.
  - A read in flight during reset is discarded and VALID_R stays 0.
- Write: a rising edge with WRITE=1 and RESET=0 stores DATA_W into reg[ADDR_W].
  - With ZERO_REG=1 and ADDR_W=0, the write is dropped.
  - WRITE=0 leaves the contents unchanged.
- Read: a rising edge with READ=1 and RESET=0 loads DATA_R1 and DATA_R2 from their addresses and sets VALID_R=1.
  - Latency is 1 cycle from the READ edge to the data and VALID_R.
  - READ=0 holds DATA_R1 and DATA_R2 at their last values and drives VALID_R=0.
  - READ held high gives back-to-back reads, one per cycle.
- Zero register: with ZERO_REG=1, a read of address 0 returns 0 regardless of any write or bypass.
- Same-edge read and write (READ=1, WRITE=1, ADDR_W equal to ADDR_Rx, and the write not dropped):
  - BYPASS=1: DATA_Rx gets DATA_W.
  - BYPASS=0: DATA_Rx gets the old contents.
  - In both cases the array is updated.
  - The two ports resolve independently; both ports reading the same address both bypass.
- Addresses are full-range and unsigned; there is no out-of-range case because DEPTH=2**ADDR_WIDTH.
- Write decode is one-hot over DEPTH (decoder-generated); at most one register loads per edge.
- No combinational path exists from any input to any output.

Test Plan:
1. Reset: write 0xDEADBEEF to reg 5, pulse RESET, then read R1=5, R2=5 -> both 0x00000000 one cycle after READ; VALID_R=1 for that cycle only.
2. Write/read: write 0xA5A5A5A5 to reg 31 and 0x00000001 to reg 1, then read R1=31, R2=1 -> 0xA5A5A5A5 and 0x00000001; with READ=0 next cycle, outputs hold and VALID_R=0.
3. Zero register: with ZERO_REG=1, write 0xFFFFFFFF to reg 0 and read reg 0 on the same and following edges -> 0 both times; with ZERO_REG=0, the next read -> 0xFFFFFFFF.
4. Bypass: reg 7 holds 0x11111111; on one edge WRITE reg 7 = 0x22222222 with READ R1=7, R2=7. BYPASS=1 -> both outputs 0x22222222; BYPASS=0 -> both outputs 0x11111111, and a following read -> 0x22222222.
5. Reset mid-operation: assert RESET on the same edge as WRITE reg 3 = 0x12345678 and READ R1=3 -> no write, outputs 0, VALID_R=0; a later read of reg 3 -> 0.
6. Parametrisation: instantiate DATA_WIDTH=16, ADDR_WIDTH=3 and write address k with k*0x1111 for k=0..7, then read all pairs -> exact values, with address 0 following ZERO_REG.
